dll_index_ctrl: RTL and testbench
=================================

# dll_index_ctrl

Adaptive controller for the DLL discriminator truncator, which selects a signed-magnitude-free 11-bit window `in[index:index-10]` from the 36-bit early/late accumulations. On each accumulation dump, the block finds the leading one of the larger of the early and late magnitudes. It then moves the window index so the window top keeps one bit of headroom. Increases apply immediately; decreases use hysteresis. The block sits between the per-channel early/late accumulators and the truncator's `index` input. It also exposes a software override.

## Interface
- `INPUT_WIDTH`, 36: accumulation width.
- `INDEX_WIDTH`, 6: index width.
- `MIN_INDEX`, 10: lowest legal index (`OUTPUT_WIDTH-1`).
- `INIT_INDEX`, 20: index after reset.
- `HOLD_DUMPS`, 4: consecutive "too large" dumps required before a decrement.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `dump` in 1: one-cycle strobe; `acc_early` and `acc_late` are valid in this cycle.
- `acc_early` in `INPUT_WIDTH`: unsigned early magnitude.
- `acc_late` in `INPUT_WIDTH`: unsigned late magnitude.
- `freeze` in 1: search still runs, but `index` is not changed.
- `cfg_load` in 1: one-cycle strobe that forces `index` to `cfg_index`.
- `cfg_index` in `INDEX_WIDTH`: override value, clamped to [`MIN_INDEX`, `INPUT_WIDTH-1`].
- `index` out `INDEX_WIDTH`: registered window index driven to the truncator.
- `index_valid` out 1: one-cycle pulse when `index` has been re-evaluated or loaded.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: one-cycle pulse when a `dump` is dropped.
- `sat` out 1: one-cycle pulse (with `index_valid`) when bit `INPUT_WIDTH-1` of the larger accumulation was set.

## Operation
- **States:** IDLE, MAX, SEARCH, ADJUST.
- **IDLE:** on `dump`, register both accumulations and go to MAX.
- **MAX:** register `m = max(early, late)` (unsigned compare; ties pick early). Set `ptr = INPUT_WIDTH-1` and go to SEARCH.
- **SEARCH:** test one bit per cycle.
  - If `m[ptr]` is 1, or `ptr == MIN_INDEX-1`, latch `p = ptr` and go to ADJUST.
  - Otherwise decrement `ptr`.
  - An all-zero `m` therefore ends with `p = MIN_INDEX-1`.
- **ADJUST:** compute `target = min(p+1, INPUT_WIDTH-1)`, so `target` is always ≥ `MIN_INDEX`.
  - If `target > index`: set `index = target` and clear `hold_cnt`.
  - If `target == index`: clear `hold_cnt`.
  - If `target < index`: increment `hold_cnt`. When it reaches `HOLD_DUMPS`, decrement `index` by exactly 1 and clear `hold_cnt`.
  - With `freeze` high during ADJUST: `index` is unchanged and `hold_cnt` is cleared.
  - In all cases, pulse `index_valid` and return to IDLE.
- **Overrun:** a `dump` while `busy` is dropped and `overrun` pulses on the next cycle. Registered data is not disturbed.
- **Load override:** `cfg_load` has priority in any state. It aborts any sequence to IDLE, sets `index` to the clamped `cfg_index`, clears `hold_cnt`, and pulses `index_valid` next cycle.
  - `cfg_load` together with `dump`: the load wins, the dump is discarded, and there is no `overrun`.
- **Reset:** overrides everything, including mid-sequence. State goes to IDLE, `index = INIT_INDEX`, `hold_cnt = 0`.

## Timing
- **Reset values:** `index = INIT_INDEX`; `index_valid`, `busy`, `overrun`, `sat` all 0.
- **Evaluation latency:** let `dump` be sampled in cycle T and `N = INPUT_WIDTH-1-p`.
  - MAX occupies T+1.
  - SEARCH occupies T+2 … T+2+N.
  - ADJUST occupies T+3+N.
  - New `index`, `index_valid` and `sat` are visible in T+4+N.
  - Minimum latency is 4 cycles. Maximum (`p = MIN_INDEX-1`) is 30 cycles with defaults.
- **`busy`:** high from T+1 through T+3+N inclusive. A `dump` at T+4+N is accepted.
- **Load latency:** `cfg_load` in cycle L gives the loaded `index` and `index_valid` in L+1, and `busy = 0` in L+1.
- **Index stability:** `index` changes only on the cycle it becomes visible, so the truncator always sees a stable value within an evaluation.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `index = 20`; `busy`, `index_valid`, `overrun` = 0.
- **Increase:** `dump` with early = 1<<30, late = 0 at T → `index = 31`, `index_valid` at T+9, `sat = 0`.
- **Saturation:** `dump` with late = 36'hF_FFFF_FFFF → `index = 35` and `sat = 1` at T+4. A second identical dump → `index` stays 35 and `hold_cnt` stays 0.
- **Hysteresis:** from `index = 20`, four dumps of early = 1<<14 (`target = 15`).
  - Dumps 1–3: `index` stays 20.
  - Dump 4: `index = 19`.
  - With `freeze` high throughout: `index` stays 20 after all four.
- **Zero input:** `dump` with both accumulations 0 → SEARCH stops at `ptr = 9`, `target = 10`, `index_valid` at T+30.
- **Overrun and load:**
  - Second `dump` at T+3 → `overrun` pulse at T+4; the first result is unaffected.
  - `cfg_load` with `cfg_index = 40` during SEARCH → `index = 35` and `busy = 0` next cycle; no stale `index_valid` follows.
  - `cfg_load` coincident with `dump` → load applied, no `overrun`.
  - `reset` mid-SEARCH → `index = 20`, IDLE.

Source files
------------

// File: rtl/dll_index_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dll_index_ctrl_if : accumulation dump / window index bus for dll_index_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
interface dll_index_ctrl_if #(
  parameter int INPUT_WIDTH = 36,
  parameter int INDEX_WIDTH = 6
);
  logic                   dump;
  logic [INPUT_WIDTH-1:0] acc_early;
  logic [INPUT_WIDTH-1:0] acc_late;
  logic                   freeze;
  logic                   cfg_load;
  logic [INDEX_WIDTH-1:0] cfg_index;
  logic [INDEX_WIDTH-1:0] index;
  logic                   index_valid;
  logic                   busy;
  logic                   overrun;
  logic                   sat;

  modport master (
    output dump, acc_early, acc_late, freeze, cfg_load, cfg_index,
    input  index, index_valid, busy, overrun, sat
  );

  modport slave (
    input  dump, acc_early, acc_late, freeze, cfg_load, cfg_index,
    output index, index_valid, busy, overrun, sat
  );
endinterface
`default_nettype wire

// File: rtl/dll_index_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dll_index_ctrl : leading-one search on early/late dumps driving truncator index
// Revision: 1.0
// ----------------------------------------------------------------------------
module dll_index_ctrl #(
  parameter int INPUT_WIDTH = 36,
  parameter int INDEX_WIDTH = 6,
  parameter int MIN_INDEX   = 10,
  parameter int INIT_INDEX  = 20,
  parameter int HOLD_DUMPS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  dll_index_ctrl_if.slave  bus
);

  localparam int HOLD_WIDTH = $clog2(HOLD_DUMPS + 1);
  localparam logic [INDEX_WIDTH-1:0] C_TOP       = INDEX_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [INDEX_WIDTH-1:0] C_MIN       = INDEX_WIDTH'(MIN_INDEX);
  localparam logic [INDEX_WIDTH-1:0] C_STOP      = INDEX_WIDTH'(MIN_INDEX - 1);
  localparam logic [INDEX_WIDTH-1:0] C_INIT      = INDEX_WIDTH'(INIT_INDEX);
  localparam logic [HOLD_WIDTH-1:0]  C_HOLD_LAST = HOLD_WIDTH'(HOLD_DUMPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAX    = 2'd1,
    S_SEARCH = 2'd2,
    S_ADJUST = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] early_q, early_d;
  logic [INPUT_WIDTH-1:0] late_q, late_d;
  logic [INPUT_WIDTH-1:0] m_q, m_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic                   index_valid_q, index_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sat_q, sat_d;
  logic [INDEX_WIDTH-1:0] target;
  logic [INDEX_WIDTH-1:0] cfg_clamped;

  always_comb begin
    state_d       = state_q;
    early_d       = early_q;
    late_d        = late_q;
    m_d           = m_q;
    ptr_d         = ptr_q;
    index_d       = index_q;
    hold_d        = hold_q;
    index_valid_d = 1'b0;
    overrun_d     = 1'b0;
    sat_d         = 1'b0;

    // ptr_q holds the stop position p once SEARCH has finished
    target = (ptr_q == C_TOP) ? C_TOP : ptr_q + 1'b1;

    if (bus.cfg_index < C_MIN) begin
      cfg_clamped = C_MIN;
    end else if (bus.cfg_index > C_TOP) begin
      cfg_clamped = C_TOP;
    end else begin
      cfg_clamped = bus.cfg_index;
    end

    if (bus.cfg_load) begin
      state_d       = S_IDLE;
      index_d       = cfg_clamped;
      hold_d        = '0;
      index_valid_d = 1'b1;
    end else begin
      overrun_d = bus.dump && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.dump) begin
            early_d = bus.acc_early;
            late_d  = bus.acc_late;
            state_d = S_MAX;
          end
        end
        S_MAX: begin
          m_d     = (late_q > early_q) ? late_q : early_q;
          ptr_d   = C_TOP;
          state_d = S_SEARCH;
        end
        S_SEARCH: begin
          if (m_q[ptr_q] || (ptr_q == C_STOP)) begin
            state_d = S_ADJUST;
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end
        S_ADJUST: begin
          index_valid_d = 1'b1;
          sat_d         = m_q[INPUT_WIDTH-1];
          state_d       = S_IDLE;
          if (bus.freeze) begin
            hold_d = '0;
          end else if (target > index_q) begin
            index_d = target;
            hold_d  = '0;
          end else if (target == index_q) begin
            hold_d = '0;
          end else if (hold_q == C_HOLD_LAST) begin
            // step down by one only; target may be far below
            index_d = index_q - 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      early_q       <= '0;
      late_q        <= '0;
      m_q           <= '0;
      ptr_q         <= '0;
      index_q       <= C_INIT;
      hold_q        <= '0;
      index_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      early_q       <= early_d;
      late_q        <= late_d;
      m_q           <= m_d;
      ptr_q         <= ptr_d;
      index_q       <= index_d;
      hold_q        <= hold_d;
      index_valid_q <= index_valid_d;
      overrun_q     <= overrun_d;
      sat_q         <= sat_d;
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overrun     = overrun_q;
  assign bus.sat         = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dll_index_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dll_index_ctrl : scoreboard bench for dll_index_ctrl with randomized dumps
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dll_index_ctrl;

  localparam int IW   = 36;
  localparam int XW   = 6;
  localparam int MINI = 10;
  localparam int INIT = 20;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dll_index_ctrl_if #(.INPUT_WIDTH(IW), .INDEX_WIDTH(XW)) bus ();

  dll_index_ctrl #(
    .INPUT_WIDTH(IW), .INDEX_WIDTH(XW), .MIN_INDEX(MINI),
    .INIT_INDEX(INIT), .HOLD_DUMPS(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [5:0]  idx;
    logic        sat;
  } exp_t;

  exp_t sbq[$];
  int   ovq[$];

  int   edges = 0;
  logic rst_s = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic armed = 1'b0;
  logic [5:0] vis_index = 6'(INIT);

  // reference model state
  int   m_idx = INIT;
  int   m_hold = 0;
  logic frz = 1'b0;
  int   busy_from = -1;
  int   busy_to = -1;
  logic pend = 1'b0;

  always @(posedge clk) begin
    edges <= edges + 1;
    rst_s <= reset;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edges, act, req);
    end
  endtask

  // monitor: outputs settle after each posedge, sampled on the negedge
  always @(negedge clk) begin
    exp_t e;
    int   k;
    logic exp_v;
    logic exp_o;
    logic exp_b;
    k = edges;
    if (rst_s) begin
      armed = 1'b1;
      vis_index = 6'(INIT);
      chk("reset_index", 64'(bus.index), 64'(INIT));
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_index_valid", 64'(bus.index_valid), 64'd0);
      chk("reset_overrun", 64'(bus.overrun), 64'd0);
      chk("reset_sat", 64'(bus.sat), 64'd0);
    end else if (armed) begin
      while (sbq.size() > 0 && sbq[0].due < k) begin
        chk("missing_index_valid", 64'd0, 64'd1);
        void'(sbq.pop_front());
      end
      exp_v = (sbq.size() > 0) && (sbq[0].due == k);
      chk("index_valid", 64'(bus.index_valid), 64'(exp_v));
      if (exp_v) begin
        e = sbq.pop_front();
        vis_index = e.idx;
        chk("sat", 64'(bus.sat), 64'(e.sat));
      end else begin
        chk("sat_without_valid", 64'(bus.sat), 64'd0);
      end
      chk("index", 64'(bus.index), 64'(vis_index));
      exp_b = (k >= busy_from) && (k < busy_to);
      chk("busy", 64'(bus.busy), 64'(exp_b));
      exp_o = (ovq.size() > 0) && (ovq[0] == k);
      if (exp_o) void'(ovq.pop_front());
      chk("overrun", 64'(bus.overrun), 64'(exp_o));
    end
  end

  // drop an in-flight evaluation when a load/reset lands at or before its ADJUST edge
  task automatic abort_eval(input int s);
    if (pend && busy_to >= s && sbq.size() > 0) void'(sbq.pop_back());
    pend = 1'b0;
    if (busy_to > s) busy_to = s;
  endtask

  task automatic model_eval(input int s, input logic [IW-1:0] ea, input logic [IW-1:0] la);
    logic [IW-1:0] m;
    int msb, p, tgt;
    m = (la > ea) ? la : ea;
    msb = -1;
    for (int i = 0; i < IW; i++) if (m[i]) msb = i;
    p   = (msb < MINI - 1) ? MINI - 1 : msb;
    tgt = (p + 1 > IW - 1) ? IW - 1 : p + 1;
    if (frz) begin
      m_hold = 0;
    end else if (tgt > m_idx) begin
      m_idx = tgt;
      m_hold = 0;
    end else if (tgt == m_idx) begin
      m_hold = 0;
    end else begin
      m_hold++;
      if (m_hold == HOLD) begin
        m_idx--;
        m_hold = 0;
      end
    end
    busy_from = s;
    busy_to   = s + (IW - 1 - p) + 3;
    pend      = 1'b1;
    sbq.push_back('{due: busy_to, idx: 6'(m_idx), sat: m[IW-1]});
  endtask

  task automatic drive(input logic d, input logic [IW-1:0] ea, input logic [IW-1:0] la,
                       input logic ld, input logic [5:0] ci, input logic rs, input logic tf);
    int s;
    int cl;
    @(posedge clk);
    #1;
    s = edges + 1;
    if (tf && s > busy_to) frz = ~frz;
    bus.dump      = d;
    bus.acc_early = ea;
    bus.acc_late  = la;
    bus.cfg_load  = ld;
    bus.cfg_index = ci;
    bus.freeze    = frz;
    reset         = rs;
    if (rs) begin
      abort_eval(s);
      m_idx = INIT;
      m_hold = 0;
    end else if (ld) begin
      abort_eval(s);
      cl = (int'(ci) < MINI) ? MINI : ((int'(ci) > IW - 1) ? IW - 1 : int'(ci));
      m_idx = cl;
      m_hold = 0;
      sbq.push_back('{due: s, idx: 6'(cl), sat: 1'b0});
    end else if (d) begin
      if ((s - 1 >= busy_from) && (s - 1 < busy_to)) ovq.push_back(s);
      else model_eval(s, ea, la);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic dump_val(input logic [IW-1:0] ea, input logic [IW-1:0] la);
    drive(1'b1, ea, la, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (edges < busy_to && n < 100) begin
      idle(1);
      n++;
    end
    if (edges < busy_to) chk("idle_timeout", 64'd1, 64'd0);
    idle(2);
  endtask

  function automatic logic [IW-1:0] rand_acc();
    logic [63:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    v = {$urandom(), $urandom()};
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return IW'(v >> $urandom_range(0, 40));
  endfunction

  initial begin
    bus.dump = 1'b0; bus.acc_early = '0; bus.acc_late = '0;
    bus.freeze = 1'b0; bus.cfg_load = 1'b0; bus.cfg_index = '0;

    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // increase, then saturation twice
    dump_val(36'd1 << 30, '0);            wait_idle();
    dump_val('0, 36'hF_FFFF_FFFF);        wait_idle();
    dump_val('0, 36'hF_FFFF_FFFF);        wait_idle();

    // hysteresis from the reset index
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0); idle(1);
    for (int i = 0; i < 4; i++) begin dump_val(36'd1 << 14, '0); wait_idle(); end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0); idle(1);
    frz = 1'b1;
    for (int i = 0; i < 4; i++) begin dump_val(36'd1 << 14, '0); wait_idle(); end
    frz = 1'b0;

    // zero input, overrun, loads, reset mid-search
    dump_val('0, '0);                     wait_idle();
    dump_val(36'd1 << 20, 36'd5);         idle(2);
    dump_val(36'd7, 36'd7);               wait_idle();
    dump_val('0, '0);                     idle(5);
    drive(1'b0, '0, '0, 1'b1, 6'd40, 1'b0, 1'b0); idle(40);
    drive(1'b1, 36'd1 << 33, '0, 1'b1, 6'd3, 1'b0, 1'b0); idle(3);
    dump_val('0, '0);                     idle(6);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0); idle(3);
    dump_val(36'd1 << 12, 36'd1 << 12);   wait_idle();

    for (int it = 0; it < 600; it++) begin
      int r;
      logic tf;
      r  = $urandom_range(0, 99);
      tf = ($urandom_range(0, 9) == 0);
      if (r < 2)       drive(1'b0, '0, '0, 1'b0, '0, 1'b1, tf);
      else if (r < 7)  drive($urandom_range(0, 1) == 1, rand_acc(), rand_acc(), 1'b1,
                             6'($urandom_range(0, 63)), 1'b0, tf);
      else if (r < 55) drive(1'b1, rand_acc(), rand_acc(), 1'b0, '0, 1'b0, tf);
      else             drive(1'b0, '0, '0, 1'b0, '0, 1'b0, tf);
    end

    wait_idle();
    idle(3);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
